// File: rtl/shift_right_seq_pkg.sv
// Shared definitions for the sequential right shifter:
// default datapath widths and the FSM state encoding.
package shift_right_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_seq.sv
// Sequential right shifter, one bit position per clock.
// Ports:
//   Clk   - clock, rising edge
//   Reset - asynchronous active-high reset
//   Start - begin a shift (sampled only in IDLE)
//   In    - operand, WIDTH bits
//   ShAmt - shift amount, SHW bits
//   Arith - 1: sign-fill shift, 0: zero-fill shift
//   Out   - result register, holds the last result
//   Busy  - high while not IDLE
//   Done  - one-cycle pulse, Out holds a new result
module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] In,
    input  logic [SHW-1:0]   ShAmt,
    input  logic             Arith,
    output logic [WIDTH-1:0] Out,
    output logic             Busy,
    output logic             Done
);

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_arith;
    logic [WIDTH-1:0] r_out;
    logic             w_fill;
    logic [WIDTH-1:0] w_acc_sh;
    logic             w_last;

    // Sign bit is replicated only in arithmetic mode.
    assign w_fill   = r_arith & r_acc[WIDTH-1];
    assign w_acc_sh = {w_fill, r_acc[WIDTH-1:1]};
    // This SHIFT edge produces the final value.
    assign w_last   = (r_cnt == CNT_ONE);

    assign Out = r_out;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_nxt = (ShAmt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                Busy        = 1'b1;
                Done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_arith <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_acc   <= In;
                        r_cnt   <= ShAmt;
                        r_arith <= Arith;
                        // Zero shift bypasses SHIFT entirely.
                        if (ShAmt == '0) begin
                            r_out <= In;
                        end
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_sh;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_last) begin
                        r_out <= w_acc_sh;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: directed vectors
// push expected results, a negedge monitor checks them.
module tb_shift_right_seq;

    localparam int W = 32;
    localparam int S = 5;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] In;
    logic [S-1:0] ShAmt;
    logic         Arith;
    logic [W-1:0] Out;
    logic         Busy;
    logic         Done;

    typedef struct {
        logic [W-1:0] out;
        int           lat;
        int           t0;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [W-1:0] prev_out = '0;
    logic prev_done = 1'b0;

    shift_right_seq #(.WIDTH(W), .SHW(S)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .In    (In),
        .ShAmt (ShAmt),
        .Arith (Arith),
        .Out   (Out),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    task automatic check(input string nm,
                         input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (Done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: Out=%h at t=%0t",
                             Out, $time);
                end else begin
                    mon_e = q.pop_front();
                    check("out", Out, mon_e.out);
                    check("latency", W'(cyc - mon_e.t0), W'(mon_e.lat));
                end
                check("done_pulse_width", W'(prev_done), '0);
                check("busy_in_done", W'(Busy), W'(1));
            end else begin
                check("out_hold", Out, prev_out);
            end
        end
        prev_out  = Out;
        prev_done = Done;
    end

    task automatic issue(input logic [W-1:0] a,
                         input logic [S-1:0] sh,
                         input logic ar,
                         input logic [W-1:0] exp,
                         input bit expect_done);
        int k = 0;
        @(negedge Clk);
        while (Busy && k < 200) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: Busy=%b expected 0", Busy);
        end
        In    = a;
        ShAmt = sh;
        Arith = ar;
        Start = 1'b1;
        if (expect_done) q.push_back('{exp, int'(sh), cyc + 1});
        @(negedge Clk);
        Start = 1'b0;
        In    = $urandom;
        ShAmt = S'($urandom);
        Arith = 1'($urandom);
    endtask

    initial begin
        int n;
        int d0;
        Reset = 1'b1;
        Start = 1'b0;
        In    = '0;
        ShAmt = '0;
        Arith = 1'b0;
        #1;
        check("reset_out", Out, '0);
        check("reset_busy", W'(Busy), '0);
        check("reset_done", W'(Done), '0);
        @(negedge Clk);
        #2 Reset = 1'b0;

        issue(32'h0000_0010, 5'd4, 1'b0, 32'h0000_0001, 1'b1);
        n = 0;
        while (Busy && n < 100) begin
            n++;
            @(negedge Clk);
        end
        check("busy_cycles", W'(n), W'(5));

        issue(32'hFFFF_FFEC, 5'd2, 1'b1, 32'hFFFF_FFFB, 1'b1);
        issue(32'hFFFF_FFEC, 5'd2, 1'b0, 32'h3FFF_FFFB, 1'b1);
        issue(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b1);
        issue(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1);
        issue(32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 1'b1);
        issue(32'hA5A5_A5A5, 5'd1, 1'b1, 32'hD2D2_D2D2, 1'b1);

        issue(32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 1'b1);
        @(negedge Clk);
        Start = 1'b1;
        In    = 32'h0000_FFFF;
        ShAmt = 5'd3;
        Arith = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        In    = 32'hDEAD_BEEF;

        issue(32'h0000_0400, 5'd10, 1'b0, '0, 1'b0);
        repeat (3) @(negedge Clk);
        d0 = done_cnt;
        #2 Reset = 1'b1;
        #1;
        check("abort_busy", W'(Busy), '0);
        check("abort_out", Out, '0);
        check("abort_done", W'(Done), '0);
        @(negedge Clk);
        #2 Reset = 1'b0;
        repeat (20) @(negedge Clk);
        check("no_done_after_abort", W'(done_cnt - d0), '0);

        issue(32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F, 1'b1);

        n = 0;
        while (q.size() != 0 && n < 200) begin
            n++;
            @(negedge Clk);
        end
        repeat (3) @(negedge Clk);
        check("queue_empty", W'(q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
